// File: rtl/rs232_input.sv
// rs232_input: UART receiver, 16x oversampled 8N1 (8E1 when PARITY_EN is defined) into a first-word-fall-through FIFO
module rs232_input #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          rxd,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [7:0]                    rd_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          irq
);
    localparam int BAUD_X  = BAUD * OVERSAMPLE;
    localparam int DIV_RAW = (CLK_HZ + BAUD_X / 2) / BAUD_X;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW      = $clog2(OVERSAMPLE);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [TW-1:0] T_S0     = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1     = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_VOTE   = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST   = TW'(OVERSAMPLE - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic            rx_meta_q, rxs_q, rxs_prev_q;
    logic [1:0]      warm_q;
    logic            armed_q;
    logic [DW-1:0]   div_q, div_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [1:0]      votes_q, votes_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            push_q, push_d;
    logic [AW:0]     wr_ptr_q, rd_ptr_q;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic            overrun_q, frame_err_q, irq_q;
    logic            ferr_set;
    logic            tick, vote, last, maj, fall;
    logic            empty, full, do_pop, do_push;
`ifdef PARITY_EN
    logic            parity_err_q, perr_set;
`endif

    assign tick    = div_q == DIV_LAST;
    assign vote    = tick && tick_cnt_q == T_VOTE;
    assign last    = tick && tick_cnt_q == T_LAST;
    assign maj     = (votes_q[1] & votes_q[0]) | (votes_q[1] & rxs_q) | (votes_q[0] & rxs_q);
    assign fall    = armed_q && rxs_prev_q && !rxs_q;

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign empty      = wr_ptr_q == rd_ptr_q;
    assign full       = fifo_count == FULL_CNT;
    assign do_pop     = rd_en && !empty;
    assign do_push    = push_q && (!full || do_pop);
    assign rd_data    = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign rx_valid   = !empty;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;
    assign irq        = irq_q;
`ifdef PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    // Receive FSM: tick timing, majority sampling, shifting and stop/parity checks
    always_comb begin
        state_d    = state_q;
        div_d      = tick ? '0 : div_q + 1'b1;
        tick_cnt_d = tick ? (last ? '0 : tick_cnt_q + 1'b1) : tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        votes_d    = (tick && (tick_cnt_q == T_S0 || tick_cnt_q == T_S1)) ? {votes_q[0], rxs_q} : votes_q;
        shreg_d    = shreg_q;
        push_d     = 1'b0;
        ferr_set   = 1'b0;
`ifdef PARITY_EN
        perr_set   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d    = S_START;
                    div_d      = '0;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            S_START: begin
                if (vote && maj)
                    state_d = S_IDLE;
                else if (last)
                    state_d = S_DATA;
            end
            S_DATA: begin
                if (vote)
                    shreg_d = {maj, shreg_q[7:1]};
                if (last) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef PARITY_EN
                    if (bit_cnt_q == 3'd7)
                        state_d = S_PARITY;
`else
                    if (bit_cnt_q == 3'd7)
                        state_d = S_STOP;
`endif
                end
            end
`ifdef PARITY_EN
            S_PARITY: begin
                if (vote)
                    perr_set = maj != ^shreg_q;
                if (last)
                    state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (vote) begin
                    ferr_set = !maj;
                    push_d   = maj;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registers: synchroniser, FSM, FIFO pointers, sticky flags (set beats clear), irq
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            rx_meta_q    <= 1'b1;
            rxs_q        <= 1'b1;
            rxs_prev_q   <= 1'b1;
            warm_q       <= 2'b00;
            armed_q      <= 1'b0;
            state_q      <= S_IDLE;
            div_q        <= '0;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            votes_q      <= '0;
            shreg_q      <= '0;
            push_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            irq_q        <= 1'b0;
`ifdef PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q    <= rxd;
            rxs_q        <= rx_meta_q;
            rxs_prev_q   <= rxs_q;
            warm_q       <= {warm_q[0], 1'b1};
            armed_q      <= armed_q | (warm_q[1] & rxs_q);
            state_q      <= state_d;
            div_q        <= div_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            votes_q      <= votes_d;
            shreg_q      <= shreg_d;
            push_q       <= push_d;
            wr_ptr_q     <= do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_q     <= do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
            overrun_q    <= (push_q && full && !do_pop) | (overrun_q & ~err_clr);
            frame_err_q  <= ferr_set | (frame_err_q & ~err_clr);
            irq_q        <= !empty;
`ifdef PARITY_EN
            parity_err_q <= perr_set | (parity_err_q & ~err_clr);
`endif
        end
    end

    // FIFO storage needs no reset because rd_data is masked while empty
    always_ff @(posedge sys_clk) begin
        if (do_push)
            mem_q[wr_ptr_q[AW-1:0]] <= shreg_q;
    end
endmodule

// File: tb/tb_rs232_input.sv
// tb_rs232_input: frame-level bench for rs232_input with a byte scoreboard (PARITY_EN adds the 8E1 cases)
`timescale 1ns/1ps
module tb_rs232_input;
    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic       rxd     = 1'b1;
    logic       rd_en   = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic [3:0] fifo_count;
    logic       overrun, frame_err, parity_err, irq;

    int         nvec    = 0;
    int         nmis    = 0;
    int         mcnt    = 0;
    logic       exp_ovr = 1'b0;
    logic [7:0] exp_q [$];

    typedef struct {
        logic [7:0] d;
        logic       stp;
        logic       ferr;
    } vec_t;

`ifdef PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    rs232_input #(.CLK_HZ(1_843_200), .BAUD(115200), .OVERSAMPLE(16), .FIFO_DEPTH(8)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .rxd       (rxd),
        .rd_en     (rd_en),
        .err_clr   (err_clr),
        .rd_data   (rd_data),
        .rx_valid  (rx_valid),
        .fifo_count(fifo_count),
        .overrun   (overrun),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .irq       (irq)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_raw(input logic [7:0] d, input logic par, input logic stp);
        logic [10:0] bits;
`ifdef PARITY_EN
        bits = {stp, par, d, 1'b0};
`else
        bits = {par, stp, d, 1'b0};
`endif
        @(posedge sys_clk);
        #1;
        for (int i = 0; i < NB; i++) begin
            rxd = bits[i];
            repeat (16) @(posedge sys_clk);
            #1;
        end
        rxd = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stp);
        send_raw(d, ^d, stp);
        if (stp) begin
            if (mcnt < 8) begin
                exp_q.push_back(d);
                mcnt++;
            end else
                exp_ovr = 1'b1;
        end
    endtask

    task automatic read_one(input string name);
        logic [7:0] e;
        @(negedge sys_clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk({name, "_data"}, 32'(rd_data), 32'(e));
        chk({name, "_valid"}, 32'(rx_valid), 32'd1);
        @(posedge sys_clk);
        #1 rd_en = 1'b1;
        @(posedge sys_clk);
        #1 rd_en = 1'b0;
        if (mcnt > 0) mcnt--;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        @(negedge sys_clk);
        while (!rx_valid && n < 400) begin
            @(negedge sys_clk);
            n++;
        end
        chk({name, "_timeout"}, 32'(rx_valid), 32'd1);
    endtask

    task automatic pulse_clr();
        @(posedge sys_clk);
        #1 err_clr = 1'b1;
        @(posedge sys_clk);
        #1 err_clr = 1'b0;
        exp_ovr = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_rd_data"}, 32'(rd_data), 32'd0);
        chk({name, "_rx_valid"}, 32'(rx_valid), 32'd0);
        chk({name, "_count"}, 32'(fifo_count), 32'd0);
        chk({name, "_overrun"}, 32'(overrun), 32'd0);
        chk({name, "_frame_err"}, 32'(frame_err), 32'd0);
        chk({name, "_parity_err"}, 32'(parity_err), 32'd0);
        chk({name, "_irq"}, 32'(irq), 32'd0);
    endtask

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        tbl = '{'{8'h00, 1'b1, 1'b0}, '{8'hFF, 1'b1, 1'b0}, '{8'h80, 1'b1, 1'b0},
                '{8'h5A, 1'b1, 1'b0}, '{8'hA3, 1'b0, 1'b1}, '{8'h01, 1'b1, 1'b0}};
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk_all_zero("reset");
        sys_rst = 1'b1;
        repeat (5) @(posedge sys_clk);

        fork
            send_frame(8'h55, 1'b1);
            begin
                wait_valid("t1");
                chk("t1_irq_lag", 32'(irq), 32'd0);
                chk("t1_rd_data", 32'(rd_data), 32'h55);
                chk("t1_count", 32'(fifo_count), 32'd1);
                @(negedge sys_clk);
                chk("t1_irq", 32'(irq), 32'd1);
            end
        join
        read_one("t1_read");
        @(negedge sys_clk);
        chk("t1_count_after_pop", 32'(fifo_count), 32'd0);
        chk("t1_irq_still", 32'(irq), 32'd1);
        @(negedge sys_clk);
        chk("t1_irq_clear", 32'(irq), 32'd0);

        @(posedge sys_clk);
        #1 rxd = 1'b0;
        repeat (4) @(posedge sys_clk);
        #1 rxd = 1'b1;
        repeat (40) @(negedge sys_clk);
        chk("t2_count", 32'(fifo_count), 32'd0);
        chk("t2_valid", 32'(rx_valid), 32'd0);
        chk("t2_frame_err", 32'(frame_err), 32'd0);

        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].d, tbl[i].stp);
            repeat (4) @(negedge sys_clk);
            chk($sformatf("vec%0d_frame_err", i), 32'(frame_err), 32'(tbl[i].ferr));
            chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(mcnt));
            chk($sformatf("vec%0d_overrun", i), 32'(overrun), 32'd0);
            if (mcnt > 0) read_one($sformatf("vec%0d", i));
            if (tbl[i].ferr) begin
                pulse_clr();
                chk($sformatf("vec%0d_err_clr", i), 32'(frame_err), 32'd0);
            end
        end

        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
        repeat (4) @(negedge sys_clk);
        chk("t4_count", 32'(fifo_count), 32'(mcnt));
        chk("t4_overrun", 32'(overrun), 32'(exp_ovr));
        chk("t4_irq", 32'(irq), 32'd1);
        for (int i = 0; i < 8; i++) read_one($sformatf("t4_read%0d", i));
        @(negedge sys_clk);
        chk("t4_valid_empty", 32'(rx_valid), 32'd0);
        chk("t4_count_empty", 32'(fifo_count), 32'd0);
        @(posedge sys_clk);
        #1 rd_en = 1'b1;
        @(posedge sys_clk);
        #1 rd_en = 1'b0;
        @(negedge sys_clk);
        chk("t4_no_underflow", 32'(fifo_count), 32'd0);
        chk("t4_empty_rd_data", 32'(rd_data), 32'd0);
        pulse_clr();
        chk("t4_overrun_clr", 32'(overrun), 32'd0);

        send_frame(8'h11, 1'b1);
        fork
            send_raw(8'hFF, 1'b0, 1'b1);
            begin
                repeat (72) @(posedge sys_clk);
                #1 chk("t5_count_before", 32'(fifo_count), 32'(mcnt));
                #1 sys_rst = 1'b0;
                #1 chk_all_zero("t5_async");
                exp_q.delete();
                mcnt = 0;
                exp_ovr = 1'b0;
                repeat (3) @(posedge sys_clk);
                #1 sys_rst = 1'b1;
            end
        join
        repeat (20) @(posedge sys_clk);
        send_frame(8'h3C, 1'b1);
        repeat (4) @(negedge sys_clk);
        chk("t5_count", 32'(fifo_count), 32'd1);
        read_one("t5_read");

`ifdef PARITY_EN
        send_raw(8'h07, 1'b0, 1'b1);
        exp_q.push_back(8'h07);
        mcnt++;
        repeat (4) @(negedge sys_clk);
        chk("t6_parity_err", 32'(parity_err), 32'd1);
        chk("t6_rd_data", 32'(rd_data), 32'h07);
        read_one("t6_read_bad");
        pulse_clr();
        chk("t6_parity_clr", 32'(parity_err), 32'd0);
        send_frame(8'h07, 1'b1);
        repeat (4) @(negedge sys_clk);
        chk("t6_parity_ok", 32'(parity_err), 32'd0);
        read_one("t6_read_good");
`endif
        @(negedge sys_clk);
        chk("end_parity_err", 32'(parity_err), 32'd0);
        chk("end_frame_err", 32'(frame_err), 32'd0);
        chk("end_empty", 32'(rx_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
